// File: rtl/addr_reader.sv
// ---------------------------------------------------------------------------
// addr_reader
//
// Read-side companion to the circular sample-buffer write address counter.
// On an accepted start it replays the most recent `len` samples from the
// buffer RAM, oldest first. It generates wrapping read addresses, absorbs
// the RAM's one-cycle read latency, and hands samples downstream over a
// valid/ready handshake through a 2-entry skid FIFO.
//
// Ports
//   CLK        clock (single domain)
//   RESETn     asynchronous active-low reset
//   start      single-cycle frame request (only honoured while idle)
//   len        number of samples to replay; 0 means "ignore the request"
//   wr_addr    current write pointer, sampled only on an accepted start
//   rd_en      RAM read strobe
//   rd_addr    RAM read address (holds its last value while rd_en is low)
//   rd_data    RAM read data, valid the cycle after rd_en
//   out_data   FIFO head sample
//   out_valid  FIFO not empty
//   out_ready  downstream accepts when out_valid && out_ready
//   busy       frame in progress
//   done       one-cycle pulse once the last sample has been accepted
// ---------------------------------------------------------------------------
module addr_reader #(
  parameter int COUNT_SIZE = 8,
  parameter int DATA_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  start,
  input  logic [COUNT_SIZE-1:0] len,
  input  logic [COUNT_SIZE-1:0] wr_addr,
  output logic                  rd_en,
  output logic [COUNT_SIZE-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [COUNT_SIZE-1:0] CNT_ZERO = {COUNT_SIZE{1'b0}};
  localparam logic [COUNT_SIZE-1:0] CNT_ONE  = {{(COUNT_SIZE-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]     DATA_ZERO = {DATA_W{1'b0}};

  // Next read address; natural modulo-2^COUNT_SIZE wrap from all-ones to 0.
  function automatic logic [COUNT_SIZE-1:0] addr_inc(input logic [COUNT_SIZE-1:0] a);
    return a + CNT_ONE;
  endfunction

  // Samples still owed to the FIFO after this cycle: stored entries, minus
  // the one leaving this cycle, plus the RAM word landing at this edge.
  function automatic logic [2:0] level_after(input logic [1:0] count,
                                             input logic       push,
                                             input logic       pop);
    return {1'b0, count} + {2'b00, push} - {2'b00, pop};
  endfunction

  // Registered state
  state_t                  state_q,      state_d;
  logic [COUNT_SIZE-1:0]   ptr_q,        ptr_d;
  logic [COUNT_SIZE-1:0]   remaining_q,  remaining_d;
  logic [COUNT_SIZE-1:0]   last_addr_q,  last_addr_d;
  logic                    inflight_q,   inflight_d;
  logic                    busy_q,       busy_d;
  logic                    done_q,       done_d;
  logic [DATA_W-1:0]       fifo_mem_q [2];
  logic [DATA_W-1:0]       fifo_mem_d [2];
  logic                    wr_idx_q,     wr_idx_d;
  logic                    rd_idx_q,     rd_idx_d;
  logic [1:0]              count_q,      count_d;

  // Handshake / issue decode
  logic                    pop_s;
  logic                    push_s;
  logic [2:0]              level_s;
  logic                    issue_s;

  // Pop, push and read-issue decisions for the current cycle. The read
  // strobe is decided combinationally so that a word issued now lands in
  // the FIFO two edges later; crediting this cycle's pop is what allows one
  // sample per cycle while never owing the FIFO more than two entries.
  always_comb begin
    pop_s   = 1'b0;
    push_s  = inflight_q;
    issue_s = 1'b0;
    if ((count_q != 2'd0) && out_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    level_s = level_after(count_q, push_s, pop_s);
    if ((state_q == STREAM) && (remaining_q != CNT_ZERO) && (level_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Frame control: start capture, address walk and completion detection.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    last_addr_d = last_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    inflight_d  = issue_s;
    case (state_q)
      IDLE: begin
        if (start && (len != CNT_ZERO)) begin
          // Oldest sample of the window ending just before wr_addr.
          ptr_d       = wr_addr - len;
          remaining_d = len;
          busy_d      = 1'b1;
          state_d     = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (issue_s) begin
          ptr_d       = addr_inc(ptr_q);
          remaining_d = remaining_q - CNT_ONE;
          last_addr_d = ptr_q;
          if (remaining_q == CNT_ONE) begin
            state_d = DRAIN;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        // Finished once nothing is in the RAM pipe and the FIFO empties now.
        if (!inflight_q && (level_s == 3'd0)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Skid FIFO bookkeeping: RAM word captured the cycle after its strobe.
  always_comb begin
    fifo_mem_d[0] = fifo_mem_q[0];
    fifo_mem_d[1] = fifo_mem_q[1];
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    count_d       = level_s[1:0];
    if (push_s) begin
      fifo_mem_d[wr_idx_q] = rd_data;
      wr_idx_d             = ~wr_idx_q;
    end else begin
      wr_idx_d = wr_idx_q;
    end
    if (pop_s) begin
      rd_idx_d = ~rd_idx_q;
    end else begin
      rd_idx_d = rd_idx_q;
    end
  end

  // Output decode: strobe/address follow the issue decision, the rest are flops.
  always_comb begin
    rd_en     = issue_s;
    rd_addr   = last_addr_q;
    out_data  = fifo_mem_q[rd_idx_q];
    out_valid = (count_q != 2'd0);
    busy      = busy_q;
    done      = done_q;
    if (issue_s) begin
      rd_addr = ptr_q;
    end else begin
      rd_addr = last_addr_q;
    end
  end

  // State registers; reset aborts any frame without a done pulse.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= IDLE;
      ptr_q         <= CNT_ZERO;
      remaining_q   <= CNT_ZERO;
      last_addr_q   <= CNT_ZERO;
      inflight_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fifo_mem_q[0] <= DATA_ZERO;
      fifo_mem_q[1] <= DATA_ZERO;
      wr_idx_q      <= 1'b0;
      rd_idx_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      remaining_q   <= remaining_d;
      last_addr_q   <= last_addr_d;
      inflight_q    <= inflight_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fifo_mem_q[0] <= fifo_mem_d[0];
      fifo_mem_q[1] <= fifo_mem_d[1];
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_addr_reader.sv
// ---------------------------------------------------------------------------
// tb_addr_reader
//
// Directed + randomized bench for addr_reader. A behavioural RAM feeds the
// DUT; the expected frame is derived directly from the buffer rule: the
// most recent len samples end just before wr_addr, oldest first, so sample
// i lives at (wr_addr - len + i) mod 256.
// ---------------------------------------------------------------------------
module tb_addr_reader;

  localparam int CS = 8;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          start;
  logic [CS-1:0] len;
  logic [CS-1:0] wr_addr;
  logic          rd_en;
  logic [CS-1:0] rd_addr;
  logic [DW-1:0] rd_data = 16'h0000;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  addr_reader #(.COUNT_SIZE(CS), .DATA_W(DW)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .start     (start),
    .len       (len),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  // Buffer RAM with one-cycle read latency
  logic [DW-1:0] mem [256];
  always @(posedge CLK) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Observation record, sampled on the falling edge
  logic [CS-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  int  done_cnt, done_cyc, last_acc_cyc, first_valid_cyc;
  int  first_issue_cyc, last_issue_cyc, issued, accepted, max_out;
  bit  busy_seen, busy_at_done;

  always @(negedge CLK) begin
    if (rd_en) begin
      obs_addr.push_back(rd_addr);
      if (issued == 0) first_issue_cyc = cyc;
      last_issue_cyc = cyc;
      issued++;
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      obs_data.push_back(out_data);
      last_acc_cyc = cyc;
      accepted++;
    end
    if (issued - accepted > max_out) max_out = issued - accepted;
    if (busy) busy_seen = 1'b1;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; first_valid_cyc = -1;
    first_issue_cyc = -1; last_issue_cyc = -1; issued = 0; accepted = 0;
    max_out = 0; busy_seen = 1'b0; busy_at_done = 1'b1;
  endtask

  // bp: 0 = always ready, 1 = 1,0,0,1,0,1 then random. inj: re-pulse start mid-frame.
  task automatic run_frame(input logic [CS-1:0] wa, input logic [CS-1:0] ln,
                           input int bp, input bit inj);
    logic [5:0]    pat;
    logic [CS-1:0] ea;
    int            start_edge;
    logic [31:0]   ov;
    pat = 6'b101001;
    clear_obs();
    wr_addr = wa; len = ln; start = 1'b1;
    start_edge = cyc + 1;
    @(posedge CLK); #1;
    start = 1'b0;
    wr_addr = CS'($urandom);
    len     = CS'($urandom_range(1, 255));
    check("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      if (bp == 0)     out_ready = 1'b1;
      else if (k < 6)  out_ready = pat[k];
      else             out_ready = 1'($urandom_range(0, 1));
      if (inj && (k == 2)) begin
        start = 1'b1; len = CS'(ln + 8'd3); wr_addr = CS'(wa + 8'd40);
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("frame_done_within_budget", 32'(done_cnt > 0), 32'd1);
    check("single_done_pulse", 32'(done_cnt), 32'd1);
    check("busy_low_with_done", 32'(busy_at_done), 32'd0);
    check("busy_low_after", 32'(busy), 32'd0);
    check("done_after_last_accept", 32'(done_cyc), 32'(last_acc_cyc + 1));
    check("first_rd_en_cycle", 32'(first_issue_cyc), 32'(start_edge));
    check("first_valid_latency", 32'(first_valid_cyc), 32'(start_edge + 2));
    check("outstanding_le_2", 32'(max_out <= 2), 32'd1);
    check("addr_count", 32'(obs_addr.size()), 32'(ln));
    check("sample_count", 32'(obs_data.size()), 32'(ln));
    for (int i = 0; i < int'(ln); i++) begin
      ea = CS'(wa - ln + CS'(i));
      ov = (i < obs_addr.size()) ? 32'(obs_addr[i]) : 32'hDEAD_BEEF;
      check("rd_addr_seq", ov, 32'(ea));
      ov = (i < obs_data.size()) ? 32'(obs_data[i]) : 32'hDEAD_BEEF;
      check("sample_data", ov, 32'(mem[ea]));
    end
    if (bp == 0) begin
      check("issue_back_to_back", 32'(last_issue_cyc - first_issue_cyc), 32'(ln - 1));
      check("accept_back_to_back", 32'(last_acc_cyc - first_valid_cyc), 32'(ln - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    RESETn = 1'b0; start = 1'b0; len = 8'h00; wr_addr = 8'h00; out_ready = 1'b0;
    clear_obs();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", 32'({rd_en, rd_addr, out_data, out_valid, busy, done}), 32'd0);
    RESETn = 1'b1;
    @(posedge CLK); #1;

    // Basic frame and wrap-around frame
    run_frame(8'h10, 8'd4, 0, 1'b0);
    run_frame(8'h02, 8'd5, 0, 1'b0);
    // Back-pressure pattern
    run_frame(8'h33, 8'd8, 1, 1'b0);
    // Restart attempt mid-frame is ignored
    run_frame(8'h50, 8'd6, 1, 1'b1);
    run_frame(8'hA0, 8'd10, 0, 1'b1);

    // len = 0 is ignored
    clear_obs();
    wr_addr = 8'h20; len = 8'd0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("len0_no_rd_en", 32'(issued), 32'd0);
    check("len0_no_busy", 32'(busy_seen), 32'd0);
    check("len0_no_done", 32'(done_cnt), 32'd0);

    // Maximum frame: everything but wr_addr, random back-pressure
    run_frame(8'h7C, 8'd255, 1, 1'b0);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      run_frame(CS'($urandom), CS'($urandom_range(1, 40)), f % 2, 1'(f == 5));
    end

    // Reset in the middle of a frame
    clear_obs();
    wr_addr = 8'h44; len = 8'd50; start = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RESETn = 1'b0;
    #1;
    check("midframe_reset_outputs", 32'({rd_en, rd_addr, out_data, out_valid, busy, done}), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("midframe_reset_no_done", 32'(done_cnt), 32'd0);
    check("midframe_reset_idle", 32'({rd_en, busy, out_valid}), 32'd0);
    run_frame(8'h80, 8'd2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
